// File: rtl/cursor_pkg.sv
// Shared types and 3x3 grid helpers for the tic-tac-toe cursor controller.
// Positions are row-major cell indices 0..8; moves wrap within their row or column.
package cursor_pkg;

    localparam int GRID_DIM  = 3;
    localparam int NUM_CELLS = GRID_DIM * GRID_DIM;
    localparam int NUM_BTNS  = 5;

    typedef enum logic [2:0] {
        UP     = 3'd0,
        DOWN   = 3'd1,
        LEFT   = 3'd2,
        RIGHT  = 3'd3,
        SELECT = 3'd4
    } btn_idx_e;

    typedef logic [3:0] pos_t;

    localparam pos_t LAST_CELL = 4'd8;

    function automatic pos_t next_right(input pos_t p);
        pos_t r;
        case (p)
            4'd0: r = 4'd1;
            4'd1: r = 4'd2;
            4'd2: r = 4'd0;
            4'd3: r = 4'd4;
            4'd4: r = 4'd5;
            4'd5: r = 4'd3;
            4'd6: r = 4'd7;
            4'd7: r = 4'd8;
            4'd8: r = 4'd6;
            default: r = p;
        endcase
        return r;
    endfunction

    function automatic pos_t next_left(input pos_t p);
        pos_t r;
        case (p)
            4'd0: r = 4'd2;
            4'd1: r = 4'd0;
            4'd2: r = 4'd1;
            4'd3: r = 4'd5;
            4'd4: r = 4'd3;
            4'd5: r = 4'd4;
            4'd6: r = 4'd8;
            4'd7: r = 4'd6;
            4'd8: r = 4'd7;
            default: r = p;
        endcase
        return r;
    endfunction

    function automatic pos_t next_down(input pos_t p);
        pos_t r;
        case (p)
            4'd0: r = 4'd3;
            4'd1: r = 4'd4;
            4'd2: r = 4'd5;
            4'd3: r = 4'd6;
            4'd4: r = 4'd7;
            4'd5: r = 4'd8;
            4'd6: r = 4'd0;
            4'd7: r = 4'd1;
            4'd8: r = 4'd2;
            default: r = p;
        endcase
        return r;
    endfunction

    function automatic pos_t next_up(input pos_t p);
        pos_t r;
        case (p)
            4'd0: r = 4'd6;
            4'd1: r = 4'd7;
            4'd2: r = 4'd8;
            4'd3: r = 4'd0;
            4'd4: r = 4'd1;
            4'd5: r = 4'd2;
            4'd6: r = 4'd3;
            4'd7: r = 4'd4;
            4'd8: r = 4'd5;
            default: r = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises one raw pushbutton, debounces it, and emits a one-cycle pulse
// on each debounced press (released-to-pressed transition only).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             raw_pressed;
    logic             sync_meta_reg;
    logic             sync_reg;
    logic             level_reg;
    logic             level_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             press_reg;
    logic             press_next;

    assign raw_pressed = ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
            level_reg     <= 1'b0;
            cnt_reg       <= '0;
            press_reg     <= 1'b0;
        end else begin
            sync_meta_reg <= raw_pressed;
            sync_reg      <= sync_meta_reg;
            level_reg     <= level_next;
            cnt_reg       <= cnt_next;
            press_reg     <= press_next;
        end
    end

    // The pulse is registered alongside the level toggle, so it is high in the
    // cycle right after the debounced level rises.
    always_comb begin
        level_next = level_reg;
        cnt_next   = cnt_reg;
        press_next = 1'b0;
        if (sync_reg == level_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            level_next = ~level_reg;
            cnt_next   = '0;
            press_next = ~level_reg;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/cursor_controller.sv
// Converts board pushbuttons into a registered cursor cell and one-cycle
// placement requests for the game-state logic.
module cursor_controller
    import cursor_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter bit   BTN_ACTIVE_LOW  = 1'b1,
    parameter pos_t RESET_POS       = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_select,
    input  logic       enable,
    input  logic [8:0] occupied,
    output logic [3:0] sel_position,
    output logic       place_valid,
    output logic [3:0] place_position
);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_press;

    pos_t sel_position_reg;
    pos_t sel_position_next;
    logic place_valid_reg;
    logic place_valid_next;
    pos_t place_position_reg;
    pos_t place_position_next;

    // Bit order follows btn_idx_e so presses can be indexed by button name.
    assign btn_raw = {btn_select, btn_right, btn_left, btn_down, btn_up};

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .ACTIVE_LOW     (BTN_ACTIVE_LOW)
            ) u_debouncer (
                .clk    (clk),
                .rst_n  (rst_n),
                .btn_raw(btn_raw[gi]),
                .press  (btn_press[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_position_reg   <= RESET_POS;
            place_valid_reg    <= 1'b0;
            place_position_reg <= '0;
        end else begin
            sel_position_reg   <= sel_position_next;
            place_valid_reg    <= place_valid_next;
            place_position_reg <= place_position_next;
        end
    end

    // One action per cycle; lower-priority presses in the same cycle are lost.
    always_comb begin
        sel_position_next   = sel_position_reg;
        place_valid_next    = 1'b0;
        place_position_next = place_position_reg;
        if (sel_position_reg > LAST_CELL) begin
            sel_position_next = RESET_POS;
        end else if (enable) begin
            if (btn_press[SELECT]) begin
                if (!occupied[sel_position_reg]) begin
                    place_valid_next    = 1'b1;
                    place_position_next = sel_position_reg;
                end
            end else if (btn_press[UP]) begin
                sel_position_next = next_up(sel_position_reg);
            end else if (btn_press[DOWN]) begin
                sel_position_next = next_down(sel_position_reg);
            end else if (btn_press[LEFT]) begin
                sel_position_next = next_left(sel_position_reg);
            end else if (btn_press[RIGHT]) begin
                sel_position_next = next_right(sel_position_reg);
            end
        end
    end

    assign sel_position   = sel_position_reg;
    assign place_valid    = place_valid_reg;
    assign place_position = place_position_reg;

endmodule
